// File: rtl/frame_capture_sequencer.sv
// frame_capture_sequencer
//   Turns a user trigger into an SDRAM write-address reload pulse. It then
//   brackets whole camera frames with start/end pulses to the CCD capture
//   stage. Continuous and single-snapshot modes are supported. Completed
//   frames are counted. A watchdog aborts with a sticky fault if iFVAL stops
//   toggling while a capture is armed or running.
//
// Ports
//   iCLK        system clock, all logic on rising edge
//   iRST_N      asynchronous active-low reset
//   iMODE       0 = continuous, 1 = snapshot (latched on accepted trigger)
//   iTRIG       rising edge requests a capture
//   iSTOP       rising edge requests a stop
//   iFVAL       camera frame-valid, already in the iCLK domain
//   oWR_LOAD    reload SDRAM write-side start addresses
//   oSTART      one-cycle begin pulse to capture stage
//   oEND        one-cycle end pulse to capture stage
//   oBUSY       high whenever not idle
//   oFRAME_CNT  completed frames, wraps
//   oFAULT      sticky watchdog fault, cleared by the next accepted trigger
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a trigger rise
// LOAD      | holding oWR_LOAD for LOAD_PULSE cycles
// WAIT_SOF  | armed, waiting for the first iFVAL rise (stop aborts here)
// CAPTURE   | frames streaming; leave at a frame end when snapshot/stop

module frame_capture_sequencer #(
    parameter int unsigned LOAD_PULSE = 4,
    parameter logic [23:0] TIMEOUT    = 24'd2_000_000,
    parameter int unsigned FRAME_W    = 16
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iMODE,
    input  logic               iTRIG,
    input  logic               iSTOP,
    input  logic               iFVAL,
    output logic               oWR_LOAD,
    output logic               oSTART,
    output logic               oEND,
    output logic               oBUSY,
    output logic [FRAME_W-1:0] oFRAME_CNT,
    output logic               oFAULT
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_WAIT_SOF = 2'd2,
        S_CAPTURE  = 2'd3
    } state_t;

    localparam logic [3:0] LOAD_INIT = 4'(LOAD_PULSE - 1);

    state_t             state, state_nxt;
    logic               trig_d, stop_d, fval_d;
    logic               trig_rise, stop_rise, fval_rise, fval_fall;
    logic [3:0]         load_cnt, load_cnt_nxt;
    logic [23:0]        wd_cnt, wd_cnt_nxt;
    logic               wd_expired;
    logic               stop_pend, stop_pend_nxt;
    logic               mode_l, mode_l_nxt;
    logic               wr_load_nxt, start_nxt, end_nxt, fault_nxt;
    logic [FRAME_W-1:0] frame_cnt_nxt;

    assign trig_rise  = iTRIG & ~trig_d;
    assign stop_rise  = iSTOP & ~stop_d;
    assign fval_rise  = iFVAL & ~fval_d;
    assign fval_fall  = ~iFVAL & fval_d;
    assign wd_expired = (wd_cnt == (TIMEOUT - 24'd1));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= S_IDLE;
            trig_d     <= 1'b0;
            stop_d     <= 1'b0;
            fval_d     <= 1'b0;
            load_cnt   <= '0;
            wd_cnt     <= '0;
            stop_pend  <= 1'b0;
            mode_l     <= 1'b0;
            oWR_LOAD   <= 1'b0;
            oSTART     <= 1'b0;
            oEND       <= 1'b0;
            oBUSY      <= 1'b0;
            oFRAME_CNT <= '0;
            oFAULT     <= 1'b0;
        end else begin
            state      <= state_nxt;
            trig_d     <= iTRIG;
            stop_d     <= iSTOP;
            fval_d     <= iFVAL;
            load_cnt   <= load_cnt_nxt;
            wd_cnt     <= wd_cnt_nxt;
            stop_pend  <= stop_pend_nxt;
            mode_l     <= mode_l_nxt;
            oWR_LOAD   <= wr_load_nxt;
            oSTART     <= start_nxt;
            oEND       <= end_nxt;
            oBUSY      <= (state_nxt != S_IDLE);
            oFRAME_CNT <= frame_cnt_nxt;
            oFAULT     <= fault_nxt;
        end
    end

    // Watchdog defaults to 0 so it is frozen in IDLE/LOAD, cleared on every
    // state entry, and cleared on any iFVAL edge; only the "no event" paths
    // below advance it.
    always_comb begin
        state_nxt     = state;
        load_cnt_nxt  = load_cnt;
        wd_cnt_nxt    = '0;
        stop_pend_nxt = stop_pend;
        mode_l_nxt    = mode_l;
        wr_load_nxt   = 1'b0;
        start_nxt     = 1'b0;
        end_nxt       = 1'b0;
        fault_nxt     = oFAULT;
        frame_cnt_nxt = oFRAME_CNT;

        case (state)
            S_IDLE: begin
                if (trig_rise) begin
                    mode_l_nxt   = iMODE;
                    fault_nxt    = 1'b0;
                    load_cnt_nxt = LOAD_INIT;
                    wr_load_nxt  = 1'b1;
                    state_nxt    = S_LOAD;
                end
            end

            S_LOAD: begin
                if (load_cnt == 4'd0) begin
                    state_nxt = S_WAIT_SOF;
                end else begin
                    load_cnt_nxt = load_cnt - 4'd1;
                    wr_load_nxt  = 1'b1;
                end
            end

            S_WAIT_SOF: begin
                // A stop wins over a coincident frame start: nothing has
                // been handed to the capture stage yet, so abort cleanly.
                if (stop_rise) begin
                    end_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (fval_rise) begin
                    start_nxt = 1'b1;
                    state_nxt = S_CAPTURE;
                end else if (fval_fall) begin
                    wd_cnt_nxt = '0;
                end else if (wd_expired) begin
                    fault_nxt     = 1'b1;
                    end_nxt       = 1'b1;
                    stop_pend_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end else begin
                    wd_cnt_nxt = wd_cnt + 24'd1;
                end
            end

            S_CAPTURE: begin
                if (stop_rise) begin
                    stop_pend_nxt = 1'b1;
                end
                if (fval_fall) begin
                    frame_cnt_nxt = oFRAME_CNT + {{(FRAME_W-1){1'b0}}, 1'b1};
                    if (mode_l || stop_pend || stop_rise) begin
                        end_nxt       = 1'b1;
                        stop_pend_nxt = 1'b0;
                        state_nxt     = S_IDLE;
                    end
                end else if (fval_rise) begin
                    wd_cnt_nxt = '0;
                end else if (wd_expired) begin
                    fault_nxt     = 1'b1;
                    end_nxt       = 1'b1;
                    stop_pend_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end else begin
                    wd_cnt_nxt = wd_cnt + 24'd1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/frame_capture_sequencer.md
# frame_capture_sequencer

Sequences camera frame capture into SDRAM for the D5M pipeline. It sits between the user controls and the capture datapath. It turns a trigger into a write-address reload pulse for the SDRAM controller's camera write ports. It then issues frame-aligned start/stop pulses to the CCD capture stage. It supports continuous and single-snapshot modes, counts completed frames, and aborts with a sticky fault if the camera stops producing frames.

## Interface
Parameters:
- LOAD_PULSE, 4, cycles `oWR_LOAD` is held high (1..15)
- TIMEOUT, 24'd2_000_000, max cycles between `iFVAL` edges while waiting/capturing before fault
- FRAME_W, 16, width of frame counter

Ports:
- `iCLK`  in  1  single clock; everything is synchronous to its rising edge
- `iRST_N`  in  1  asynchronous, active-low reset
- `iMODE`  in  1  0 = continuous, 1 = snapshot; sampled only on an accepted trigger
- `iTRIG`  in  1  level, synchronous to `iCLK`; rising edge requests capture
- `iSTOP`  in  1  level, synchronous; rising edge requests stop
- `iFVAL`  in  1  camera frame-valid, already registered into the `iCLK` domain
- `oWR_LOAD`  out  1  high = reload SDRAM write-side start addresses
- `oSTART`  out  1  one-cycle pulse to capture stage: begin
- `oEND`  out  1  one-cycle pulse to capture stage: end
- `oBUSY`  out  1  high in any state except IDLE
- `oFRAME_CNT`  out  FRAME_W  completed frames, wraps modulo 2^FRAME_W
- `oFAULT`  out  1  sticky watchdog fault

## Operation
- Edge detection: internal registers `trig_d`, `stop_d`, and `fval_d`, all reset to 0. A rise is `x & ~x_d`; a fall is `~x & x_d`.
- Reset: state is IDLE. All outputs are 0. The load counter, watchdog, `stop_pend`, and `mode_l` are all 0.
- IDLE: on `iTRIG` rise, latch `mode_l = iMODE`, clear `oFAULT`, and go to LOAD.
- LOAD: hold `oWR_LOAD` = 1 for exactly LOAD_PULSE cycles, then go to WAIT_SOF.
- WAIT_SOF:
  - On `iFVAL` rise, pulse `oSTART` and go to CAPTURE.
  - On `iSTOP` rise, pulse `oEND` and go to IDLE. No frame is counted.
- CAPTURE, on `iFVAL` fall:
  - Increment `oFRAME_CNT`.
  - If `mode_l` = 1 or `stop_pend` = 1: pulse `oEND`, clear `stop_pend`, and go to IDLE.
  - Otherwise stay in CAPTURE.
- CAPTURE, on `iSTOP` rise: set `stop_pend`. The frame in progress completes first.
- Watchdog, in WAIT_SOF and CAPTURE:
  - Counts up each cycle and clears on any `iFVAL` edge and on state entry.
  - When count reaches TIMEOUT-1: set `oFAULT`, pulse `oEND`, clear `stop_pend`, and go to IDLE.
  - Frozen at 0 in IDLE and LOAD.
- Simultaneous events:
  - A trigger outside IDLE is ignored.
  - A stop in IDLE or LOAD is ignored.
  - `iSTOP` rise and `iFVAL` fall in the same CAPTURE cycle: the frame is counted and the block ends (same as `stop_pend` already set).
  - Watchdog expiry and an `iFVAL` edge in the same cycle: the edge wins; the watchdog clears.
  - `iTRIG` rise and `iSTOP` rise together in IDLE: the trigger is accepted.
- `oSTART` and `oEND` are never high in the same cycle. `oEND` is high for exactly one cycle per exit from WAIT_SOF or CAPTURE.
- Reset asserted mid-operation: all state and outputs return immediately (asynchronously) to reset values. `oFRAME_CNT` also returns to 0.

## Timing
- All outputs are registered. No combinational path from input to output.
- Trigger rise sampled at edge n: `oBUSY` = 1 and `oWR_LOAD` = 1 from edge n+1 through edge n+LOAD_PULSE. The state is WAIT_SOF at edge n+LOAD_PULSE+1.
- `iFVAL` rise sampled at edge m in WAIT_SOF: `oSTART` = 1 for cycle m+1 only.
- `iFVAL` fall sampled at edge m in CAPTURE:
  - `oFRAME_CNT` updates at m+1.
  - If ending, `oEND` = 1 for cycle m+1 and `oBUSY` = 0 from m+1.
- Watchdog: with no `iFVAL` edge, fault and `oEND` appear TIMEOUT cycles after entering WAIT_SOF/CAPTURE.
- The earliest re-trigger accepted is the cycle after return to IDLE.

## Test plan
Parameters for all scenarios: LOAD_PULSE = 4, TIMEOUT = 100, frames are 20 cycles high and 10 low.
- Reset release, all inputs 0 for 20 cycles -> all outputs 0 and `oBUSY` = 0.
- Snapshot: `iMODE` = 1, pulse `iTRIG` ->
  - `oWR_LOAD` high for exactly 4 cycles.
  - `oSTART` one cycle after the next `iFVAL` rise.
  - `oEND` one cycle after that frame's fall.
  - `oFRAME_CNT` = 1, then IDLE.
- Continuous: `iMODE` = 0, trigger, run 3 frames, raise `iSTOP` mid-frame 4 ->
  - `oFRAME_CNT` = 4.
  - `oEND` one cycle after frame 4 falls.
  - No `oEND` earlier.
- Watchdog: trigger with `iFVAL` held 0 -> `oFAULT` = 1 and `oEND` pulse 100 cycles after WAIT_SOF entry. A new trigger clears `oFAULT`.
- Edge cases:
  - `iTRIG` re-pulsed during CAPTURE -> no `oWR_LOAD`, count unaffected.
  - `iSTOP` in WAIT_SOF -> `oEND` next cycle, count unchanged.
  - `iSTOP` rise coincident with `iFVAL` fall -> count +1 and end.
- Async reset mid-CAPTURE with `oFRAME_CNT` = 7 -> all outputs 0 without waiting for a clock edge; IDLE after release.
